// File: rtl/sata_link_speed_pkg.sv
// Shared types and helpers for the SATA link speed negotiation controller.
package sata_link_speed_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_RWAIT = 3'd2,
    S_XWAIT = 3'd3,
    S_LWAIT = 3'd4,
    S_UP    = 3'd5,
    S_FAIL  = 3'd6
  } neg_state_t;

  localparam logic [1:0] SATA_GEN1 = 2'd1;
  localparam logic [1:0] SATA_GEN2 = 2'd2;
  localparam logic [1:0] SATA_GEN3 = 2'd3;

  // A requested generation of 0 is meaningless; treat it as Gen1.
  function automatic logic [1:0] clamp_gen(input logic [1:0] g);
    return (g == 2'd0) ? SATA_GEN1 : g;
  endfunction

endpackage

// File: rtl/sata_link_speed_ctrl_if.sv
// Reconfiguration handshake between the speed controller and the transceiver wrapper.
interface sata_link_speed_ctrl_if;
  logic       recfg_request;
  logic [1:0] recfg_sata_gen;
  logic       recfg_ready;

  modport master (output recfg_request, output recfg_sata_gen, input recfg_ready);
  modport slave  (input recfg_request, input recfg_sata_gen, output recfg_ready);
endinterface

// File: rtl/sata_sync2.sv
// Two-flop synchronizer for single-bit level signals from the transceiver clock domain.
module sata_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  // Two-stage capture; the first stage may go metastable, the second settles it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/sata_link_speed_ctrl.sv
// SATA speed negotiation: try the highest allowed generation, step down on timeout.
//
// state | meaning
// IDLE  | nothing configured, waiting for start
// REQ   | reconfiguration request held until the wrapper accepts it
// RWAIT | wrapper reconfiguring; first cycle ignores recfg_ready
// XWAIT | waiting for synchronized rx/tx ready, bounded by XCVR_TIMEOUT
// LWAIT | link layer allowed to run, waiting for link_ok, bounded by LINK_TIMEOUT
// UP    | link established and held
// FAIL  | Gen1 also failed; only start leaves
module sata_link_speed_ctrl
  import sata_link_speed_pkg::*;
#(
  parameter int XCVR_TIMEOUT = 1_000_000,
  parameter int LINK_TIMEOUT = 2_000_000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [1:0]                    max_gen,
  sata_link_speed_ctrl_if.master        recfg,
  input  logic                          rx_ready,
  input  logic                          tx_ready,
  output logic                          link_try,
  input  logic                          link_ok,
  output logic [1:0]                    cur_gen,
  output logic                          link_up,
  output logic                          neg_fail
);

  localparam int TMAX = (XCVR_TIMEOUT > LINK_TIMEOUT) ? XCVR_TIMEOUT : LINK_TIMEOUT;
  localparam int TW   = $clog2(TMAX);

  neg_state_t    r_state;
  neg_state_t    w_next_state;
  logic [1:0]    r_gen;
  logic [1:0]    w_next_gen;
  logic [1:0]    r_max_gen;
  logic          r_start_pend;
  logic [TW-1:0] r_timer;
  logic          w_rx_s;
  logic          w_tx_s;
  logic          w_step;
  logic          w_timer_clr;
  logic          w_recfg_request;
  logic [1:0]    w_recfg_gen;

  sata_sync2 u_sync_rx (.clk(clk), .reset(reset), .i_d(rx_ready), .o_q(w_rx_s));
  sata_sync2 u_sync_tx (.clk(clk), .reset(reset), .i_d(tx_ready), .o_q(w_tx_s));

  // The RWAIT guard cycle relies on the timer still being 0, so a start deferred
  // inside RWAIT must not clear it.
  assign w_timer_clr = (w_next_state != r_state) || (start && (r_state != S_RWAIT));

  // State, generation, stored max_gen, deferred-start flag and timer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_gen        <= 2'd0;
      r_max_gen    <= 2'd0;
      r_start_pend <= 1'b0;
      r_timer      <= '0;
    end else begin
      r_state <= w_next_state;
      r_gen   <= w_next_gen;
      if (start) r_max_gen <= max_gen;
      if ((r_state == S_RWAIT) && (w_next_state != S_RWAIT)) r_start_pend <= 1'b0;
      else if (start && (r_state == S_RWAIT))                r_start_pend <= 1'b1;
      if (w_timer_clr)              r_timer <= '0;
      else if (r_timer != '1)       r_timer <= r_timer + 1'b1;
    end
  end

  // Next state and generation.
  always_comb begin
    w_next_state = r_state;
    w_next_gen   = r_gen;
    w_step       = 1'b0;
    if (start && (r_state != S_RWAIT)) begin
      w_next_state = S_REQ;
      w_next_gen   = clamp_gen(max_gen);
    end else begin
      case (r_state)
        S_IDLE: ;
        S_REQ: if (recfg.recfg_ready) w_next_state = S_RWAIT;
        S_RWAIT: begin
          if ((r_timer != '0) && recfg.recfg_ready) begin
            if (r_start_pend || start) begin
              w_next_state = S_REQ;
              w_next_gen   = start ? clamp_gen(max_gen) : clamp_gen(r_max_gen);
            end else begin
              w_next_state = S_XWAIT;
            end
          end
        end
        S_XWAIT: begin
          if (w_rx_s && w_tx_s)                          w_next_state = S_LWAIT;
          else if (r_timer == TW'(XCVR_TIMEOUT - 1))     w_step = 1'b1;
        end
        S_LWAIT: begin
          if (link_ok)                                   w_next_state = S_UP;
          else if (r_timer == TW'(LINK_TIMEOUT - 1))     w_step = 1'b1;
        end
        S_UP: begin
          if (!link_ok || !w_rx_s) begin
            w_next_state = S_REQ;
            w_next_gen   = clamp_gen(r_max_gen);
          end
        end
        S_FAIL: ;
        default: w_next_state = S_IDLE;
      endcase
      if (w_step) begin
        if (r_gen > SATA_GEN1) begin
          w_next_state = S_REQ;
          w_next_gen   = r_gen - SATA_GEN1;
        end else begin
          w_next_state = S_FAIL;
          w_next_gen   = SATA_GEN1;
        end
      end
    end
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    w_recfg_request = 1'b0;
    w_recfg_gen     = 2'd0;
    link_try        = 1'b0;
    cur_gen         = 2'd0;
    link_up         = 1'b0;
    neg_fail        = 1'b0;
    case (r_state)
      S_REQ: begin
        w_recfg_request = 1'b1;
        w_recfg_gen     = r_gen;
        cur_gen         = r_gen;
      end
      S_RWAIT, S_XWAIT: cur_gen = r_gen;
      S_LWAIT: begin
        cur_gen  = r_gen;
        link_try = 1'b1;
      end
      S_UP: begin
        cur_gen  = r_gen;
        link_try = 1'b1;
        link_up  = 1'b1;
      end
      S_FAIL: begin
        cur_gen  = SATA_GEN1;
        neg_fail = 1'b1;
      end
      default: ;
    endcase
  end

  assign recfg.recfg_request  = w_recfg_request;
  assign recfg.recfg_sata_gen = w_recfg_gen;

endmodule

// File: doc/sata_link_speed_ctrl.md
# sata_link_speed_ctrl

Speed-negotiation controller for the SATA transceiver wrapper, in the reconfiguration clock domain. On a start request it reconfigures the transceiver to the highest allowed SATA generation, waits for transceiver readiness and then for the link layer to report an established link. On timeout it steps down one generation and retries. It drives the wrapper's `recfg_request`/`recfg_sata_gen` handshake and reports the negotiated generation upward.

## Interface
Parameters:
- `XCVR_TIMEOUT`, 1_000_000: cycles allowed for `rx_ready`&`tx_ready` after reconfiguration completes (≥2).
- `LINK_TIMEOUT`, 2_000_000: cycles allowed for `link_ok` after `link_try` rises (≥2).

Ports:
- `clk` in 1: reconfiguration clock (same as wrapper `reconfig_clk`).
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; (re)starts negotiation from any state.
- `max_gen` in 2: highest generation allowed (1..3; 0 treated as 1); sampled on `start`.
- `recfg_request` out 1: reconfiguration request to wrapper.
- `recfg_sata_gen` out 2: target generation, valid while `recfg_request`=1.
- `recfg_ready` in 1: wrapper reconfiguration engine idle/ready.
- `rx_ready` in 1: async (gxb_refclk domain), synchronized internally.
- `tx_ready` in 1: async (gxb_refclk domain), synchronized internally.
- `link_try` out 1: permits link layer to run OOB/alignment at `cur_gen`.
- `link_ok` in 1: link layer reports link established (level, `clk` domain).
- `cur_gen` out 2: generation currently configured/being tried (0 = none).
- `link_up` out 1: negotiation succeeded, link held.
- `neg_fail` out 1: Gen1 also failed; sticky until `start`.

## Operation
- States: IDLE, REQ, RWAIT, XWAIT, LWAIT, UP, FAIL.
- IDLE: all outputs 0. `start` → REQ; gen ← clamp(`max_gen`).
- REQ: `recfg_request`=1, `recfg_sata_gen`=gen, `cur_gen`=gen. Transfer occurs on the cycle `recfg_request`&`recfg_ready`=1 → RWAIT. Request held until accepted.
- RWAIT: first cycle is a guard cycle (ready ignored; the wrapper drops `recfg_ready` on the cycle after acceptance). Then wait for `recfg_ready`=1 → XWAIT, timer cleared. No timeout.
- XWAIT: `rx_ready_s`&`tx_ready_s`=1 → LWAIT, timer cleared. Timer reaching `XCVR_TIMEOUT`-1 → STEP.
- LWAIT: `link_try`=1. `link_ok`=1 → UP. Timer reaching `LINK_TIMEOUT`-1 → STEP.
- STEP (a transition, not a state): if gen>1, gen ← gen−1 → REQ; else → FAIL.
- UP: `link_up`=1, `link_try`=1. Loss of `link_ok` or of `rx_ready_s` → REQ with gen ← clamp(stored `max_gen`); this is a full renegotiation.
- FAIL: `neg_fail`=1, `cur_gen` holds 1, `link_try`=0. Only `start` exits.
- `start` in any state: stored `max_gen` updated, gen ← clamp, → REQ next cycle, timer cleared. In RWAIT, `start` is deferred until RWAIT exits, so an accepted reconfiguration is never abandoned; it then goes to REQ.
- Single timer, width `$clog2(max(XCVR_TIMEOUT,LINK_TIMEOUT))`, saturating; cleared on every state change.

## Timing
- Reset values: all outputs 0; state IDLE; timer 0; synchronizers 0.
- All outputs are registered (Moore) and change one cycle after the causing input edge.
- `start` → `recfg_request`=1: 1 cycle.
- Ready synchronizers: 2 flops. `rx_ready`/`tx_ready` edge seen at the FSM after 2–3 cycles.
- `link_ok`=1 in LWAIT → `link_up`=1 next cycle.
- When `link_ok` and the timeout occur in the same cycle, `link_ok` wins. Same rule for ready vs timeout in XWAIT.
- `link_try` drops in the same cycle that `recfg_request` rises on a step-down.

## Structure
- Package `sata_link_speed_pkg`: state enum `neg_state_t`; constants `SATA_GEN1`=2'd1, `SATA_GEN2`=2'd2, `SATA_GEN3`=2'd3; function `clamp_gen`.
- Sub-module `sata_sync2`: 2-flop synchronizer with async active-low reset. Instantiated for `rx_ready` and `tx_ready`.

## Test plan
- `max_gen`=3; ready responds in 4 cycles; `rx_ready`/`tx_ready` high; `link_ok` after 10 cycles → one request with gen 3, `cur_gen`=3, `link_up`=1.
- `max_gen`=3; `link_ok` never asserted, `LINK_TIMEOUT`=16 → requests gen 3, then 2, then 1, then `neg_fail`=1, `cur_gen`=1, `link_try`=0.
- `recfg_ready` held low for 20 cycles in REQ → `recfg_request` stays high with gen stable; exactly one transfer counted.
- In UP, drop `link_ok` → `link_up`=0 next cycle; new request at stored `max_gen`.
- `start` with `max_gen`=2 during RWAIT → RWAIT completes, then request gen 2. With `max_gen`=0 → gen 1.
- Assert `reset` low mid-LWAIT → all outputs 0 asynchronously; IDLE after release.
